// File: rtl/edge_event_unit.sv
// edge_event_unit: per-channel edge detector with sticky flags, saturating counters and a single-entry event report. Rev 1.0
// Optional EDGE_SYNC2_EN inserts a two-flop input synchronizer and stretches the arming delay to 4 cycles.
`default_nettype none

module edge_event_unit #(
  parameter int NCH  = 4,
  parameter int CNTW = 8,
  parameter int CHW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      sig_in,
  input  logic [2*NCH-1:0]    mode,
  input  logic [NCH-1:0]      clr,
  input  logic [NCH-1:0]      irq_mask,
  input  logic                evt_ready,
  output logic [NCH-1:0]      event_pulse,
  output logic [NCH-1:0]      sticky,
  output logic [NCH*CNTW-1:0] count,
  output logic                evt_valid,
  output logic [CHW-1:0]      evt_chan,
  output logic                evt_ovf,
  output logic                irq
);

  logic [NCH-1:0]   w_stage_in;
  logic [NCH-1:0]   r_cur;
  logic [NCH-1:0]   r_prev;
  logic [2*NCH-1:0] r_mode;
  logic [2:0]       r_arm;
  logic             w_armed;
  logic [NCH-1:0]   w_evt;
  logic [NCH-1:0]   r_pulse;
  logic [NCH-1:0]   r_sticky;
  logic [CNTW-1:0]  r_cnt [NCH];
  logic             r_valid;
  logic [CHW-1:0]   r_chan;
  logic             r_ovf;
  logic [CHW-1:0]   w_low;
  logic             w_any;
  logic             w_multi;
  logic             w_hs;

`ifdef EDGE_SYNC2_EN
  localparam logic [2:0] ARM_CYCLES = 3'd4;
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_stage_in = r_sync2;
`else
  localparam logic [2:0] ARM_CYCLES = 3'd2;
  assign w_stage_in = sig_in;
`endif

  // Arming counter: edges are only trusted once every history flop holds a post-reset sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur  <= '0;
      r_prev <= '0;
      r_mode <= '0;
      r_arm  <= '0;
    end else begin
      r_cur  <= w_stage_in;
      r_prev <= r_cur;
      r_mode <= mode;
      if (r_arm != ARM_CYCLES) r_arm <= r_arm + 3'd1;
    end
  end

  assign w_armed = (r_arm == ARM_CYCLES);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_edge
      assign w_evt[gi] = w_armed &
                         ((r_mode[2*gi]   & r_cur[gi] & ~r_prev[gi]) |
                          (r_mode[2*gi+1] & ~r_cur[gi] & r_prev[gi]));
      assign count[CNTW*gi +: CNTW] = r_cnt[gi];
    end
  endgenerate

  always_comb begin
    w_low = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_evt[i]) w_low = CHW'(i);
    end
  end

  assign w_any   = |w_evt;
  assign w_multi = |(w_evt & (w_evt - 1'b1));
  assign w_hs    = r_valid & evt_ready;

  // A clear coinciding with an event leaves the event counted once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse  <= '0;
      r_sticky <= '0;
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      r_pulse <= w_evt;
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          r_cnt[i]    <= CNTW'(w_evt[i]);
          r_sticky[i] <= w_evt[i];
        end else if (w_evt[i]) begin
          r_sticky[i] <= 1'b1;
          if (r_cnt[i] != {CNTW{1'b1}}) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (!r_valid || w_hs) begin
        r_valid <= w_any;
        if (w_any) r_chan <= w_low;
      end
      if (w_multi || (w_any && r_valid && !evt_ready)) r_ovf <= 1'b1;
      else if (w_hs)                                   r_ovf <= 1'b0;
    end
  end

  assign event_pulse = r_pulse;
  assign sticky      = r_sticky;
  assign evt_valid   = r_valid;
  assign evt_chan    = r_chan;
  assign evt_ovf     = r_ovf;
  assign irq         = |(r_sticky & irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_edge_event_unit.sv
// tb_edge_event_unit: directed scenarios plus randomized traffic against a sample-history reference model.
`default_nettype none

module tb_edge_event_unit;

  localparam int NCH  = 4;
  localparam int CNTW = 3;
  localparam int CHW  = 2;
  localparam int CMAX = (1 << CNTW) - 1;
`ifdef EDGE_SYNC2_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      sig_in;
  logic [2*NCH-1:0]    mode;
  logic [NCH-1:0]      clr;
  logic [NCH-1:0]      irq_mask;
  logic                evt_ready;
  logic [NCH-1:0]      event_pulse;
  logic [NCH-1:0]      sticky;
  logic [NCH*CNTW-1:0] count;
  logic                evt_valid;
  logic [CHW-1:0]      evt_chan;
  logic                evt_ovf;
  logic                irq;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit [NCH-1:0]   q[$];
  bit [2*NCH-1:0] m_mode1;
  int             m_cnt [NCH];
  bit [NCH-1:0]   m_sticky;
  bit [NCH-1:0]   m_pulse;
  bit             m_valid;
  int             m_chan;
  bit             m_ovf;

  edge_event_unit #(.NCH(NCH), .CNTW(CNTW), .CHW(CHW)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .mode(mode), .clr(clr),
    .irq_mask(irq_mask), .evt_ready(evt_ready), .event_pulse(event_pulse),
    .sticky(sticky), .count(count), .evt_valid(evt_valid), .evt_chan(evt_chan),
    .evt_ovf(evt_ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock from the currently driven inputs, then clock the DUT.
  task automatic step();
    bit [NCH-1:0] e;
    int nev, low;
    bit hs;
    e = '0;
    if (reset) begin
      q.delete();
      m_mode1 = '0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_sticky = '0; m_pulse = '0; m_valid = 0; m_chan = 0; m_ovf = 0;
    end else begin
      if (q.size() >= LAT) begin
        for (int i = 0; i < NCH; i++) begin
          bit c, p;
          bit [1:0] md;
          c  = q[LAT-2][i];
          p  = q[LAT-1][i];
          md = m_mode1[2*i +: 2];
          if ((md == 2'b01 && c && !p) || (md == 2'b10 && !c && p) || (md == 2'b11 && c != p))
            e[i] = 1'b1;
        end
      end
      nev = $countones(e);
      low = 0;
      for (int i = NCH - 1; i >= 0; i--) if (e[i]) low = i;
      hs = m_valid && evt_ready;
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          m_cnt[i] = e[i] ? 1 : 0;
          m_sticky[i] = e[i];
        end else if (e[i]) begin
          m_sticky[i] = 1'b1;
          if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (nev > 1 || (nev > 0 && m_valid && !evt_ready)) m_ovf = 1;
      else if (hs) m_ovf = 0;
      if (!m_valid || hs) begin
        if (nev > 0) begin m_valid = 1; m_chan = low; end
        else m_valid = 0;
      end
      m_pulse = e;
      q.push_front(sig_in);
      if (q.size() > LAT) void'(q.pop_back());
      m_mode1 = mode;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sig_in = '0; mode = '0; clr = '0; irq_mask = '1; evt_ready = 1'b0;
    do_reset();
    n_tests++;
    if (event_pulse !== '0 || sticky !== '0) begin
      n_fail++; $display("FAIL reset_flags: pulse=%b sticky=%b required 0", event_pulse, sticky);
    end
    n_tests++;
    if (count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %h required 0", count);
    end
    n_tests++;
    if (evt_valid !== 1'b0 || evt_chan !== '0 || evt_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_evt: valid=%b chan=%0d ovf=%b required 0", evt_valid, evt_chan, evt_ovf);
    end
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b required 0", irq);
    end
  endtask

  task automatic test_modes();
    int pc [NCH];
    for (int i = 0; i < NCH; i++) pc[i] = 0;
    sig_in = '0; mode = 8'b11_10_01_00; clr = '0; irq_mask = '0; evt_ready = 1'b1;
    do_reset();
    repeat (LAT + 2) step();
    sig_in = 4'hF;
    repeat (LAT + 2) begin
      step();
      for (int i = 0; i < NCH; i++) pc[i] += event_pulse[i];
    end
    sig_in = 4'h0;
    repeat (LAT + 2) begin
      step();
      for (int i = 0; i < NCH; i++) pc[i] += event_pulse[i];
    end
    n_tests++;
    if (pc[0] != 0 || pc[1] != 1 || pc[2] != 1 || pc[3] != 2) begin
      n_fail++; $display("FAIL mode_pulses: got %0d %0d %0d %0d required 0 1 1 2", pc[0], pc[1], pc[2], pc[3]);
    end
    n_tests++;
    if (count !== {3'd2, 3'd1, 3'd1, 3'd0}) begin
      n_fail++; $display("FAIL mode_counts: got %h required %h", count, {3'd2, 3'd1, 3'd1, 3'd0});
    end
  endtask

  task automatic test_saturate();
    sig_in = '0; mode = 8'h01; clr = '0; irq_mask = '0; evt_ready = 1'b1;
    do_reset();
    repeat (LAT + 2) step();
    for (int k = 0; k < 9; k++) begin
      sig_in[0] = 1'b1; repeat (2) step();
      sig_in[0] = 1'b0; repeat (2) step();
    end
    repeat (LAT) step();
    n_tests++;
    if (count[CNTW-1:0] !== 3'd7) begin
      n_fail++; $display("FAIL saturate_count: got %0d required 7", count[CNTW-1:0]);
    end
    n_tests++;
    if (sticky[0] !== 1'b1) begin
      n_fail++; $display("FAIL saturate_sticky: got %b required 1", sticky[0]);
    end
  endtask

  task automatic test_ovf();
    sig_in = '0; mode = 8'hFF; clr = '0; irq_mask = '0; evt_ready = 1'b0;
    do_reset();
    repeat (LAT + 2) step();
    sig_in = 4'b0110;
    repeat (LAT) step();
    n_tests++;
    if (event_pulse !== 4'b0110) begin
      n_fail++; $display("FAIL ovf_pulse: got %b required 0110", event_pulse);
    end
    n_tests++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd1 || evt_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: valid=%b chan=%0d ovf=%b required 1 1 1", evt_valid, evt_chan, evt_ovf);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    n_tests++;
    if (evt_valid !== 1'b0 || evt_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: valid=%b ovf=%b required 0 0", evt_valid, evt_ovf);
    end
  endtask

  task automatic test_clr();
    sig_in = '0; mode = 8'h03; clr = '0; irq_mask = 4'h1; evt_ready = 1'b1;
    do_reset();
    repeat (LAT + 2) step();
    sig_in[0] = 1'b1;
    repeat (LAT + 1) step();
    sig_in[0] = 1'b0;
    repeat (LAT - 1) step();
    clr = 4'h1;
    step();
    clr = '0;
    n_tests++;
    if (count[CNTW-1:0] !== 3'd1 || sticky[0] !== 1'b1) begin
      n_fail++; $display("FAIL clr_with_event: count=%0d sticky=%b required 1 1", count[CNTW-1:0], sticky[0]);
    end
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL clr_irq_set: got %b required 1", irq);
    end
    repeat (2) step();
    clr = 4'h1;
    step();
    clr = '0;
    n_tests++;
    if (count[CNTW-1:0] !== 3'd0 || sticky[0] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL clr_alone: count=%0d sticky=%b irq=%b required 0 0 0", count[CNTW-1:0], sticky[0], irq);
    end
  endtask

  task automatic test_arm_latency();
    bit seen;
    sig_in = 4'hF; mode = 8'hFF; clr = '0; irq_mask = '1; evt_ready = 1'b1;
    do_reset();
    seen = 0;
    repeat (6) begin
      step();
      if (event_pulse !== '0 || sticky !== '0) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL arm_quiet: pulse=%b sticky=%b required 0 after held-high release", event_pulse, sticky);
    end
    sig_in = 4'h0;
    repeat (LAT - 1) step();
    n_tests++;
    if (event_pulse !== '0) begin
      n_fail++; $display("FAIL latency_early: got %b required 0000", event_pulse);
    end
    step();
    n_tests++;
    if (event_pulse !== 4'hF) begin
      n_fail++; $display("FAIL latency_pulse: got %b required 1111", event_pulse);
    end
    step();
    n_tests++;
    if (event_pulse !== '0) begin
      n_fail++; $display("FAIL latency_single: got %b required 0000", event_pulse);
    end
  endtask

  task automatic test_random();
    bit [NCH*CNTW-1:0] exp_count;
    sig_in = '0; mode = $urandom; clr = '0; irq_mask = $urandom; evt_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      sig_in    = ($urandom % 3 == 0) ? NCH'($urandom) : sig_in;
      if ($urandom % 16 == 0) mode = $urandom;
      clr       = ($urandom % 8 == 0) ? NCH'($urandom) : '0;
      irq_mask  = ($urandom % 8 == 0) ? NCH'($urandom) : irq_mask;
      evt_ready = ($urandom % 3 != 0);
      reset     = ($urandom % 150 == 0);
      step();
      for (int i = 0; i < NCH; i++) exp_count[CNTW*i +: CNTW] = CNTW'(m_cnt[i]);
      n_tests++;
      if (event_pulse !== m_pulse || sticky !== m_sticky || count !== exp_count) begin
        n_fail++;
        $display("FAIL rand_chan cyc%0d: pulse=%b sticky=%b count=%h required %b %b %h",
                 n, event_pulse, sticky, count, m_pulse, m_sticky, exp_count);
      end
      n_tests++;
      if (evt_valid !== m_valid || evt_chan !== CHW'(m_chan) || evt_ovf !== m_ovf ||
          irq !== |(m_sticky & irq_mask)) begin
        n_fail++;
        $display("FAIL rand_evt cyc%0d: valid=%b chan=%0d ovf=%b irq=%b required %b %0d %b %b",
                 n, evt_valid, evt_chan, evt_ovf, irq, m_valid, m_chan, m_ovf, |(m_sticky & irq_mask));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sig_in = '0; mode = '0; clr = '0; irq_mask = '0; evt_ready = 1'b0;
    test_reset();
    test_modes();
    test_saturate();
    test_ovf();
    test_clr();
    test_arm_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
